cordic_ci_master: RTL and testbench

- Initiator side of the multi-cycle custom-instruction interface (clk_en/start/dataa/result/done) used by the fixed-point CORDIC cosine slave.
- Accepts FP32 operands on a valid/ready request port and runs one slave transaction per operand.
- Returns the FP32 result, or a timeout indication, on a valid/ready response port.
- Used as the hardware driver and test harness for any slave that follows this protocol.

---
 rtl/cordic_ci_master.sv | 174 +++++++++++++++++
 tb/tb_cordic_ci_master.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_ci_master.sv
// cordic_ci_master
// Initiator for the multi-cycle custom-instruction protocol
// (clk_en/start/dataa/result/done) used by the CORDIC cosine slave.
// It takes one FP32 operand per request handshake, runs one slave
// transaction, and returns the slave result or a timeout indication.
// Optional feature: define CI_CYCLE_COUNT_EN to add the rsp_cycles output
// (WAIT cycles spent on the returned operation).
module cordic_ci_master #(
  parameter int                 DATA_W         = 32,
  parameter int                 TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0]  NAN_VALUE      = DATA_W'(32'h7FC00000)
) (
  input  logic              clock,
  input  logic              aclr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
`ifdef CI_CYCLE_COUNT_EN
  output logic [7:0]        rsp_cycles,
`endif
  output logic              ci_aclr,
  output logic              ci_clk_en,
  output logic              ci_start,
  output logic [DATA_W-1:0] ci_dataa,
  input  logic [DATA_W-1:0] ci_result,
  input  logic              ci_done,
  output logic              busy
);

  // The counter holds TIMEOUT_CYCLES-1 with a spare bit, so it can saturate
  // instead of wrapping.
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    counter, counter_nx;
  logic                req_ready_nx;
  logic                rsp_valid_nx;
  logic [DATA_W-1:0]   rsp_data_nx;
  logic                rsp_timeout_nx;
  logic                ci_aclr_nx;
  logic                ci_clk_en_nx;
  logic                ci_start_nx;
  logic [DATA_W-1:0]   ci_dataa_nx;
`ifdef CI_CYCLE_COUNT_EN
  logic [7:0]          rsp_cycles_nx;
`endif

  // Next-state and next-output logic; every output is the registered copy of its _nx value.
  always_comb begin
    state_nx       = state;
    counter_nx     = counter;
    req_ready_nx   = req_ready;
    rsp_valid_nx   = rsp_valid;
    rsp_data_nx    = rsp_data;
    rsp_timeout_nx = rsp_timeout;
    ci_aclr_nx     = 1'b0;
    ci_clk_en_nx   = 1'b0;
    ci_start_nx    = 1'b0;
    ci_dataa_nx    = ci_dataa;
`ifdef CI_CYCLE_COUNT_EN
    rsp_cycles_nx  = rsp_cycles;
`endif

    case (state)
      IDLE: begin
        req_ready_nx = 1'b1;
        if (req_valid && req_ready) begin
          state_nx     = START;
          req_ready_nx = 1'b0;
          ci_dataa_nx  = req_data;
          ci_start_nx  = 1'b1;
          ci_clk_en_nx = 1'b1;
          counter_nx   = '0;
        end
      end

      START: begin
        state_nx     = WAIT;
        ci_clk_en_nx = 1'b1;
        counter_nx   = '0;
      end

      WAIT: begin
        ci_clk_en_nx = 1'b1;
        if (counter != CNT_MAX) begin
          counter_nx = counter + CNT_W'(1);
        end
        // A done seen on the last allowed cycle still counts as a result.
        if (ci_done) begin
          state_nx       = RESP;
          ci_clk_en_nx   = 1'b0;
          rsp_valid_nx   = 1'b1;
          rsp_data_nx    = ci_result;
          rsp_timeout_nx = 1'b0;
`ifdef CI_CYCLE_COUNT_EN
          rsp_cycles_nx  = 8'(counter) + 8'd1;
`endif
        end else if (counter >= CNT_LAST) begin
          state_nx       = RESP;
          ci_clk_en_nx   = 1'b0;
          ci_aclr_nx     = 1'b1;
          rsp_valid_nx   = 1'b1;
          rsp_data_nx    = NAN_VALUE;
          rsp_timeout_nx = 1'b1;
`ifdef CI_CYCLE_COUNT_EN
          rsp_cycles_nx  = 8'(TIMEOUT_CYCLES);
`endif
        end
      end

      RESP: begin
        // clk_en stays low here so the slave is frozen with its done held.
        if (rsp_ready) begin
          state_nx     = IDLE;
          rsp_valid_nx = 1'b0;
          req_ready_nx = 1'b1;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // State and output registers; reset holds the slave in clear and blocks requests.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state       <= IDLE;
      counter     <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
      ci_aclr     <= 1'b1;
      ci_clk_en   <= 1'b0;
      ci_start    <= 1'b0;
      ci_dataa    <= '0;
      busy        <= 1'b0;
`ifdef CI_CYCLE_COUNT_EN
      rsp_cycles  <= 8'd0;
`endif
    end else begin
      state       <= state_nx;
      counter     <= counter_nx;
      req_ready   <= req_ready_nx;
      rsp_valid   <= rsp_valid_nx;
      rsp_data    <= rsp_data_nx;
      rsp_timeout <= rsp_timeout_nx;
      ci_aclr     <= ci_aclr_nx;
      ci_clk_en   <= ci_clk_en_nx;
      ci_start    <= ci_start_nx;
      ci_dataa    <= ci_dataa_nx;
      busy        <= (state_nx != IDLE);
`ifdef CI_CYCLE_COUNT_EN
      rsp_cycles  <= rsp_cycles_nx;
`endif
    end
  end

endmodule

// File: tb/tb_cordic_ci_master.sv
// tb_cordic_ci_master
// Scoreboard bench for cordic_ci_master with a behavioural slave whose done
// delay, result and stale-done behaviour are chosen per operation.
// Build with CI_CYCLE_COUNT_EN defined to also check rsp_cycles.
module tb_cordic_ci_master;

  localparam int          TO  = 8;
  localparam logic [31:0] NAN = 32'h7FC00000;

  typedef struct {
    logic [31:0] data;
    bit          timeout;
    int          cycles;
    int          lat;
    int          t_hs;
    int          stall;
  } rsp_item_t;

  typedef struct {
    logic [31:0] operand;
    int          t_hs;
  } start_item_t;

  logic        clock;
  logic        aclr_n;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
`ifdef CI_CYCLE_COUNT_EN
  logic [7:0]  rsp_cycles;
`endif
  logic        ci_aclr;
  logic        ci_clk_en;
  logic        ci_start;
  logic [31:0] ci_dataa;
  logic [31:0] ci_result;
  logic        ci_done;
  logic        busy;

  rsp_item_t   exp_q[$];
  start_item_t start_q[$];
  int          checks   = 0;
  int          errors   = 0;
  int          cyc      = 0;
  int          n_issued = 0;
  int          n_rsp    = 0;

  // Slave configuration chosen by the stimulus, latched by the slave at start.
  int          cfg_delay  = 5;
  logic [31:0] cfg_result = 32'd0;
  logic        force_done = 1'b0;

  cordic_ci_master #(
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO),
    .NAN_VALUE      (NAN)
  ) dut (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_data    (req_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
`ifdef CI_CYCLE_COUNT_EN
    .rsp_cycles  (rsp_cycles),
`endif
    .ci_aclr     (ci_aclr),
    .ci_clk_en   (ci_clk_en),
    .ci_start    (ci_start),
    .ci_dataa    (ci_dataa),
    .ci_result   (ci_result),
    .ci_done     (ci_done),
    .busy        (busy)
  );

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter used for latency checks.
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural slave: done rises on WAIT cycle 'delay' (0 = never) and stays
  // high while clk_en is low; ci_aclr clears it synchronously.
  logic        sl_active  = 1'b0;
  int          sl_elapsed = 0;
  int          sl_delay   = 0;
  logic [31:0] sl_result  = 32'd0;

  always @(posedge clock) begin
    if (ci_aclr) begin
      sl_active  <= 1'b0;
      sl_elapsed <= 0;
    end else if (ci_clk_en) begin
      if (ci_start) begin
        sl_active  <= 1'b1;
        sl_elapsed <= 1;
        sl_delay   <= cfg_delay;
        sl_result  <= cfg_result;
      end else if (sl_active && sl_elapsed < 1000) begin
        sl_elapsed <= sl_elapsed + 1;
      end
    end
  end

  assign ci_done   = force_done | (sl_active && sl_delay != 0 && sl_elapsed >= sl_delay);
  assign ci_result = sl_result;

  // Single comparison point: counts every check and reports each failure.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Every output at its reset value.
  task automatic checkResetValues();
    checkOutput("rst_req_ready",   32'(req_ready),   32'd0);
    checkOutput("rst_rsp_valid",   32'(rsp_valid),   32'd0);
    checkOutput("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
    checkOutput("rst_rsp_data",    rsp_data,         32'd0);
    checkOutput("rst_ci_clk_en",   32'(ci_clk_en),   32'd0);
    checkOutput("rst_ci_start",    32'(ci_start),    32'd0);
    checkOutput("rst_ci_dataa",    ci_dataa,         32'd0);
    checkOutput("rst_ci_aclr",     32'(ci_aclr),     32'd1);
    checkOutput("rst_busy",        32'(busy),        32'd0);
`ifdef CI_CYCLE_COUNT_EN
    checkOutput("rst_rsp_cycles",  32'(rsp_cycles),  32'd0);
`endif
  endtask

  // Issue one operation and push its expected outcome. Expected response
  // follows the rules directly: done within TO wait cycles returns the
  // slave result after delay cycles, otherwise NaN with timeout after TO.
  task automatic applyStimulus(input logic [31:0] operand, input logic [31:0] result,
                               input int delay, input int stall, input bit stale,
                               input bit junk, output int t_hs);
    int          guard;
    rsp_item_t   it;
    start_item_t st;
    guard = 0;
    t_hs  = -1;
    @(negedge clock);
    while (!(aclr_n && req_ready) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 200) begin
      checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
      return;
    end
    cfg_delay  = delay;
    cfg_result = result;
    force_done = stale;
    req_valid  = 1'b1;
    req_data   = operand;
    t_hs       = cyc;
    if (delay >= 1 && delay <= TO) begin
      it.data = result; it.timeout = 1'b0; it.cycles = delay; it.lat = delay + 2;
    end else begin
      it.data = NAN;    it.timeout = 1'b1; it.cycles = TO;    it.lat = TO + 2;
    end
    it.t_hs  = t_hs;
    it.stall = stall;
    st.operand = operand;
    st.t_hs    = t_hs;
    exp_q.push_back(it);
    start_q.push_back(st);
    n_issued++;
    @(negedge clock);
    req_valid = junk;
    req_data  = ~operand;
    if (stale || junk) begin
      @(negedge clock);
      force_done = 1'b0;
      if (junk) begin
        @(negedge clock);
        req_valid = 1'b0;
      end
    end
  endtask

  // Wait until every issued operation has been answered.
  task automatic waitDrain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || start_q.size() != 0) && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    checkOutput("drain_pending", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clock);
  endtask

  // Monitor and consumer: compares starts and responses against the queues
  // and drives rsp_ready with the per-operation backpressure.
  logic first_seen    = 1'b0;
  int   stall_left    = 0;
  logic chk_idle_next = 1'b0;

  always @(negedge clock) begin
    logic first_now;
    if (!aclr_n) begin
      rsp_ready     = 1'b0;
      first_seen    = 1'b0;
      chk_idle_next = 1'b0;
    end else begin
      if (chk_idle_next) begin
        checkOutput("req_ready_after_hs", 32'(req_ready), 32'd1);
        checkOutput("rsp_valid_dropped",  32'(rsp_valid), 32'd0);
        chk_idle_next = 1'b0;
      end
      if (ci_start) begin
        if (start_q.size() == 0) begin
          checkOutput("unexpected_start", 32'(ci_start), 32'd0);
        end else begin
          checkOutput("ci_dataa",       ci_dataa,                  start_q[0].operand);
          checkOutput("start_cycle",    32'(cyc - start_q[0].t_hs), 32'd1);
          checkOutput("start_clk_en",   32'(ci_clk_en),            32'd1);
          void'(start_q.pop_front());
        end
      end
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_rsp_valid", 32'(rsp_valid), 32'd0);
          rsp_ready = 1'b1;
        end else begin
          first_now = !first_seen;
          if (first_now) begin
            first_seen = 1'b1;
            stall_left = exp_q[0].stall;
            checkOutput("latency", 32'(cyc - exp_q[0].t_hs), 32'(exp_q[0].lat));
          end
          checkOutput("rsp_data",      rsp_data,          exp_q[0].data);
          checkOutput("rsp_timeout",   32'(rsp_timeout),  32'(exp_q[0].timeout));
`ifdef CI_CYCLE_COUNT_EN
          checkOutput("rsp_cycles",    32'(rsp_cycles),   32'(exp_q[0].cycles));
`endif
          checkOutput("ci_aclr_pulse", 32'(ci_aclr),      32'(exp_q[0].timeout && first_now));
          checkOutput("resp_clk_en",   32'(ci_clk_en),    32'd0);
          checkOutput("resp_req_rdy",  32'(req_ready),    32'd0);
          checkOutput("resp_busy",     32'(busy),         32'd1);
          if (stall_left > 0) begin
            rsp_ready = 1'b0;
            stall_left--;
          end else begin
            rsp_ready = 1'b1;
            void'(exp_q.pop_front());
            first_seen    = 1'b0;
            chk_idle_next = 1'b1;
            n_rsp++;
          end
        end
      end else begin
        rsp_ready = 1'b0;
      end
    end
  end

  // Hard stop if something never finishes.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios, a randomized batch, then reset during WAIT.
  initial begin
    int t;
    aclr_n = 1'b1;
    #1 aclr_n = 1'b0;
    #1 checkResetValues();
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetValues();
    aclr_n = 1'b1;
    @(negedge clock);
    checkOutput("first_edge_req_ready", 32'(req_ready), 32'd1);
    checkOutput("first_edge_ci_aclr",   32'(ci_aclr),   32'd0);

    $display("[TB] single operation");
    applyStimulus(32'h3F000000, 32'h3F5A5A5A, 5, 0, 1'b0, 1'b0, t);
    $display("[TB] backpressure with junk request pulses");
    applyStimulus($urandom, $urandom, 3, 3, 1'b0, 1'b1, t);
    $display("[TB] stale done through IDLE and START");
    applyStimulus($urandom, $urandom, 4, 0, 1'b1, 1'b0, t);
    $display("[TB] timeout");
    applyStimulus($urandom, $urandom, 0, 1, 1'b0, 1'b0, t);
    $display("[TB] done on final wait cycle and one past it");
    applyStimulus($urandom, $urandom, TO, 0, 1'b0, 1'b0, t);
    applyStimulus($urandom, $urandom, TO + 1, 2, 1'b0, 1'b0, t);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      applyStimulus($urandom, $urandom, int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0, t);
    end
    waitDrain();

    $display("[TB] reset during WAIT");
    applyStimulus($urandom, $urandom, 0, 0, 1'b0, 1'b0, t);
    @(negedge clock);
    @(negedge clock);
    aclr_n = 1'b0;
    #1;
    checkResetValues();
    n_issued -= exp_q.size();
    exp_q.delete();
    start_q.delete();
    repeat (2) @(negedge clock);
    checkResetValues();
    aclr_n = 1'b1;
    applyStimulus($urandom, $urandom, 6, 1, 1'b0, 1'b0, t);
    waitDrain();

    checkOutput("response_count", 32'(n_rsp), 32'(n_issued));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
